unary_result_decoder: RTL and testbench

Downstream consumer of the unary MAC's serial output: converts each unary run (k consecutive 1s terminated by a 0) into a k-valued binary word and queues it behind a valid/ready handshake for binary-domain logic (accumulator readback, CSR capture, DMA). It sits directly on the MAC `out` wire. It absorbs back-pressure with a small result FIFO so the MAC never stalls. Results that cannot be queued are dropped and flagged.

---
 rtl/unary_dec_pkg.sv | 26 ++
 rtl/result_fifo.sv | 62 ++++++
 rtl/unary_result_decoder.sv | 137 +++++++++++++
 tb/tb_unary_result_decoder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/unary_dec_pkg.sv
// Shared types and helpers for the unary result decoder.
// Build option: UNARY_DEC_DROP_CNT_EN (drop_count port and counter, in the top).
package unary_dec_pkg;

  // Decoder FSM states.
  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // Run-length counter width: a BIN_BITS x BIN_BITS product plus an addend.
  function automatic int unsigned out_w(input int unsigned bin_bits);
    return 2 * bin_bits + 1;
  endfunction

  localparam int unsigned DEF_BIN_BITS = 4;
  localparam int unsigned DEF_OUT_W    = 2 * DEF_BIN_BITS + 1;

  // Queued result layout at the default operand width. The top builds the
  // same {sat, value} layout sized for its own BIN_BITS.
  typedef struct packed {
    logic                 sat;
    logic [DEF_OUT_W-1:0] value;
  } result_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous result FIFO. Head is read combinationally from registered
// storage. A push into a full FIFO succeeds when a pop happens on the same
// edge. A pop on an empty FIFO is ignored. DEPTH must be a power of 2, >= 2.
module result_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               data_in,
  output logic [WIDTH-1:0]               data_out,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] count;
  logic             wr_en;
  logic             rd_en;

  assign empty    = (count == '0);
  assign full     = (count == LVL_W'(DEPTH));
  assign rd_en    = pop && !empty;
  assign wr_en    = push && (!full || rd_en);
  assign data_out = mem[rd_ptr];
  assign level    = count;

  // Storage write; cleared on reset so the head reads 0 when nothing is queued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointer and occupancy update; power-of-2 depth lets pointers wrap freely.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/unary_result_decoder.sv
// Unary run decoder: counts runs of 1s on the MAC serial output and queues
// each run length behind a valid/ready handshake. Results that find the
// queue full (with no same-cycle pop) are dropped and flagged.
// Build option: UNARY_DEC_DROP_CNT_EN adds the 16-bit saturating drop_count.
//
// state | meaning
// IDLE  | line idle (0s), no run in progress
// COUNT | counting 1s of a run; the next 0 ends it and queues the result
module unary_result_decoder
  import unary_dec_pkg::*;
#(
  parameter int BIN_BITS   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              in,
  input  logic                              clear,
  output logic [out_w(BIN_BITS)-1:0]        out_data,
  output logic                              out_sat,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              overflow
`ifdef UNARY_DEC_DROP_CNT_EN
  ,
  output logic [15:0]                       drop_count
`endif
);

  localparam int OUT_W = out_w(BIN_BITS);
  localparam logic [OUT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] value;
  } entry_t;

  state_t           state;
  logic [OUT_W-1:0] cnt;
  logic             sat;
  entry_t           push_entry;
  entry_t           head;
  logic             push_req;
  logic             do_push;
  logic             do_pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;

  // A run ends on the first 0 seen in COUNT; it is dropped only if the queue
  // is full and no entry leaves on the same edge.
  assign push_req   = (state == COUNT) && !in;
  assign do_pop     = !fifo_empty && out_ready;
  assign drop       = push_req && fifo_full && !do_pop;
  assign do_push    = push_req && !drop;
  assign push_entry = '{sat: sat, value: cnt};

  assign out_valid  = !fifo_empty;
  assign out_data   = head.value;
  assign out_sat    = head.sat;

  // Run FSM with saturating counter; busy is registered and mirrors COUNT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      sat   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in) begin
            state <= COUNT;
            cnt   <= OUT_W'(1);
            sat   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        COUNT: begin
          if (in) begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (cnt == CNT_MAX - 1'b1) sat <= 1'b1;
          end else begin
            state <= IDLE;
            cnt   <= '0;
            sat   <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          sat   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as clear keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   overflow <= 1'b0;
    else if (drop)  overflow <= 1'b1;
    else if (clear) overflow <= 1'b0;
  end

`ifdef UNARY_DEC_DROP_CNT_EN
  // Saturating drop counter; a drop in the same cycle as clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (drop) begin
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end else if (clear) begin
      drop_count <= '0;
    end
  end
`endif

  result_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (do_push),
    .pop      (do_pop),
    .data_in  (push_entry),
    .data_out (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

endmodule

// File: tb/tb_unary_result_decoder.sv
// Scoreboard bench for unary_result_decoder: default instance (BIN_BITS=4)
// checked against a reference model, plus a BIN_BITS=2 instance for saturation.
module tb_unary_result_decoder;

  localparam int DEPTH   = 4;
  localparam int OUT_W   = 9;
  localparam int CNT_MAX = 511;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_s;
  logic        clear;
  logic        out_ready;
  logic [8:0]  out_data;
  logic        out_sat;
  logic        out_valid;
  logic        busy;
  logic [2:0]  level;
  logic        overflow;
  logic [15:0] drop_count;

  logic        d2_ready = 1'b1;
  logic [4:0]  d2_data;
  logic        d2_sat;
  logic        d2_valid;
  logic        d2_busy;
  logic [2:0]  d2_level;
  logic        d2_overflow;
  logic [15:0] d2_drop;

  always #5 clk = ~clk;

  unary_result_decoder #(.BIN_BITS(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk), .reset_n (reset_n), .in (in_s), .clear (clear),
    .out_data (out_data), .out_sat (out_sat), .out_valid (out_valid),
    .out_ready (out_ready), .busy (busy), .level (level), .overflow (overflow)
`ifdef UNARY_DEC_DROP_CNT_EN
    , .drop_count (drop_count)
`endif
  );

  unary_result_decoder #(.BIN_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .clk (clk), .reset_n (reset_n), .in (in_s), .clear (clear),
    .out_data (d2_data), .out_sat (d2_sat), .out_valid (d2_valid),
    .out_ready (d2_ready), .busy (d2_busy), .level (d2_level), .overflow (d2_overflow)
`ifdef UNARY_DEC_DROP_CNT_EN
    , .drop_count (d2_drop)
`endif
  );

`ifndef UNARY_DEC_DROP_CNT_EN
  assign drop_count = '0;
  assign d2_drop    = '0;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // reference model
  int          m_cnt;
  bit          m_sat;
  bit          m_ovf;
  int          m_drops;
  logic [9:0]  exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_sat   = 0;
    m_ovf   = 0;
    m_drops = 0;
    exp_q.delete();
  endtask

  // One clock of stimulus: drive in, check DUT against the model at the
  // falling edge, then advance the model to what the rising edge will do.
  task automatic step(input logic v);
    bit drop_now;
    in_s = v;
    @(negedge clk);
    check_eq("level", 32'(level), 32'(exp_q.size()));
    check_eq("valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check_eq("busy", 32'(busy), 32'(m_cnt != 0));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
`ifdef UNARY_DEC_DROP_CNT_EN
    check_eq("drop_count", 32'(drop_count), 32'(m_drops));
`endif
    if (exp_q.size() > 0) begin
      check_eq("head", 32'({out_sat, out_data}), 32'(exp_q[0]));
      if (out_ready) void'(exp_q.pop_front());
    end
    drop_now = 0;
    if (m_cnt != 0 && !v) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m_sat, OUT_W'(m_cnt)});
      else begin
        drop_now = 1;
        m_ovf    = 1;
        if (m_drops < 65535) m_drops++;
      end
      m_cnt = 0;
      m_sat = 0;
    end else if (v) begin
      if (m_cnt == 0) begin
        m_cnt = 1;
        m_sat = 0;
      end else if (m_cnt < CNT_MAX) begin
        m_cnt++;
        if (m_cnt == CNT_MAX) m_sat = 1;
      end
    end
    if (clear && !drop_now) begin
      m_ovf   = 0;
      m_drops = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_valid"}, 32'(out_valid), 0);
    check_eq({tag, "_data"}, 32'(out_data), 0);
    check_eq({tag, "_sat"}, 32'(out_sat), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_level"}, 32'(level), 0);
    check_eq({tag, "_ovf"}, 32'(overflow), 0);
    check_eq({tag, "_drops"}, 32'(drop_count), 0);
  endtask

  initial begin
    logic pat2 [11];
    pat2 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    reset_n   = 1'b0;
    in_s      = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    check_eq("reset_d2_valid", 32'(d2_valid), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // single run of 3, consumer ready
    out_ready = 1'b1;
    repeat (3) step(1'b1);
    step(1'b0);
    check_eq("t1_valid", 32'(out_valid), 1);
    check_eq("t1_data", 32'(out_data), 3);
    check_eq("t1_sat", 32'(out_sat), 0);
    repeat (2) step(1'b0);
    check_eq("t1_level", 32'(level), 0);

    // back-to-back runs 1,1,0,1,0 -> 2 then 1
    foreach (pat2[i]) if (i < 0) step(1'b0);
    step(1'b1); step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    repeat (3) step(1'b0);

    // three runs queued while stalled, then drained
    out_ready = 1'b0;
    foreach (pat2[i]) step(pat2[i]);
    step(1'b0);
    check_eq("t2_level", 32'(level), 3);
    check_eq("t2_head", 32'(out_data), 1);
    out_ready = 1'b1;
    repeat (3) step(1'b0);
    check_eq("t2_drained", 32'(level), 0);

    // saturation on the narrow instance
    repeat (40) step(1'b1);
    step(1'b0);
    check_eq("t3_d2_valid", 32'(d2_valid), 1);
    check_eq("t3_d2_data", 32'(d2_data), 31);
    check_eq("t3_d2_sat", 32'(d2_sat), 1);
    check_eq("t3_data", 32'(out_data), 40);
    repeat (2) step(1'b0);

    // overflow: six runs into a 4-deep stalled queue
    out_ready = 1'b0;
    repeat (6) begin
      step(1'b1);
      step(1'b0);
    end
    step(1'b0);
    check_eq("t4_level", 32'(level), 4);
    check_eq("t4_ovf", 32'(overflow), 1);
`ifdef UNARY_DEC_DROP_CNT_EN
    check_eq("t4_drops", 32'(drop_count), 2);
`endif
    clear = 1'b1;
    step(1'b0);
    clear = 1'b0;
    check_eq("t4_clr_ovf", 32'(overflow), 0);
    check_eq("t4_clr_drops", 32'(drop_count), 0);
    check_eq("t4_clr_level", 32'(level), 4);

    // push into full queue with same-cycle pop: no drop
    step(1'b1);
    out_ready = 1'b1;
    step(1'b0);
    out_ready = 1'b0;
    check_eq("t5_level", 32'(level), 4);
    check_eq("t5_ovf", 32'(overflow), 0);
    step(1'b0);

    // clear coinciding with a drop: drop wins
    step(1'b1);
    clear = 1'b1;
    step(1'b0);
    clear = 1'b0;
    check_eq("t5b_ovf", 32'(overflow), 1);
`ifdef UNARY_DEC_DROP_CNT_EN
    check_eq("t5b_drops", 32'(drop_count), 1);
`endif
    out_ready = 1'b1;
    repeat (5) step(1'b0);

    // reset in the middle of a run
    repeat (3) step(1'b1);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("midrst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    in_s    = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    check_eq("t6_data", 32'(out_data), 2);
    repeat (2) step(1'b0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 31) == 0);
      step(($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
    end
    clear     = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 2) step(1'b0);
    check_eq("final_level", 32'(level), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
